// File: rtl/decode_stage.sv
// RV32I decode stage: turns a fetched instruction + PC into the execute control word.
// Latency: 1 cycle from input handshake to out_valid; throughput 1/cycle while out_ready is high.
// Backpressure: stalls hold the output word stable; in_ready = !out_valid || out_ready by default,
//   or a registered "skid entry empty" when DECODE_SKID_BUFFER_EN is defined (2 entries held).
//
// Ports: clock/reset (sync, active-high), flush; in_valid/in_ready/instruction/pc from fetch;
//   out_valid/out_ready/pc_out/ALU_Control/branch_op/imm/rs1/rs2/rd/op_a_sel/op_b_sel/
//   reg_write/mem_read/mem_write/jump/illegal toward execute.
// Build option: DECODE_SKID_BUFFER_EN adds a second entry and cuts out_ready -> in_ready.

module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [5:0]      ALU_Control,
  output logic            branch_op,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [1:0]      op_a_sel,
  output logic            op_b_sel,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            jump,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      alu_ctrl;
    logic            branch_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [1:0]      op_a_sel;
    logic            op_b_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            jump;
    logic            illegal;
  } dec_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALU block select, ALU_Control[4:3]
  localparam logic [1:0] BLK_ARITH = 2'b00;
  localparam logic [1:0] BLK_ALT   = 2'b01;
  localparam logic [1:0] BLK_BR    = 2'b10;
  localparam logic [1:0] BLK_JUMP  = 2'b11;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  dec_t            dec;
  dec_t            out_q;
  logic            out_valid_q;
  logic            accept;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u  = {instruction[31:12], 12'b0};
  assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
  // Shift-immediates carry only the shift amount; funct7 bits are not part of the operand.
  assign imm_sh = {27'b0, instruction[24:20]};

  always_comb begin
    dec     = '0;
    dec.pc  = pc;
    dec.rs1 = instruction[19:15];
    dec.rs2 = instruction[24:20];
    dec.rd  = instruction[11:7];
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000)
          dec.alu_ctrl = {1'b0, BLK_ARITH, funct3};
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.alu_ctrl = {1'b0, BLK_ALT, funct3};
        else
          dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.op_b_sel  = 1'b1;
        dec.imm       = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
        // Only SRAI uses the alternate block; ADDI with bit 30 set stays plain ADD.
        dec.alu_ctrl  = (funct3 == 3'b101 && funct7[5]) ? {1'b0, BLK_ALT, funct3}
                                                        : {1'b0, BLK_ARITH, funct3};
      end
      OPC_BRANCH: begin
        dec.alu_ctrl  = {1'b0, BLK_BR, funct3};
        dec.branch_op = 1'b1;
        dec.imm       = imm_b;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU produces the link value PC+4; the target adder lives downstream.
        dec.alu_ctrl  = {1'b0, BLK_JUMP, 3'b000};
        dec.op_a_sel  = 2'b10;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = (opcode == OPC_JAL) ? imm_j : imm_i;
      end
      OPC_LUI: begin
        dec.op_a_sel  = 2'b11;
        dec.op_b_sel  = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.op_a_sel  = 2'b01;
        dec.op_b_sel  = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_LOAD: begin
        dec.op_b_sel  = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.op_b_sel  = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal words travel on as harmless bubbles: no state-changing control may survive.
    if (dec.illegal) begin
      dec.alu_ctrl  = '0;
      dec.imm       = '0;
      dec.op_a_sel  = '0;
      dec.op_b_sel  = 1'b0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.jump      = 1'b0;
      dec.branch_op = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;

`ifdef DECODE_SKID_BUFFER_EN
  dec_t skid_q;
  logic skid_valid_q;

  // Registered ready: a word can always land in out_q or, if that is stalled, in the skid slot.
  assign in_ready = !skid_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees up: the older skid word has precedence over a new arrival.
      // accept cannot be high while the skid slot is full.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid   = out_valid_q;
  assign pc_out      = out_q.pc;
  assign ALU_Control = out_q.alu_ctrl;
  assign branch_op   = out_q.branch_op;
  assign imm         = out_q.imm;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign op_a_sel    = out_q.op_a_sel;
  assign op_b_sel    = out_q.op_b_sel;
  assign reg_write   = out_q.reg_write;
  assign mem_read    = out_q.mem_read;
  assign mem_write   = out_q.mem_write;
  assign jump        = out_q.jump;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed decode vectors, stall/hold, flush and a randomized
// run against a queue-based reference of the stage's transfer rules.
// Works in both the default build and with DECODE_SKID_BUFFER_EN defined.

module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instruction, pc;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, imm;
  logic [5:0]  ALU_Control;
  logic        branch_op;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  op_a_sel;
  logic        op_b_sel, reg_write, mem_read, mem_write, jump, illegal;

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .ALU_Control(ALU_Control), .branch_op(branch_op), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .jump(jump), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  alu;
    logic        br;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  asel;
    logic        bsel;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        j;
    logic        ill;
  } dec_t;

`ifdef DECODE_SKID_BUFFER_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  dec_t obs;
  logic obs_in_ready, obs_out_valid;

  // Expected decode computed directly from the instruction-set rules.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
    dec_t        d;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic        bad;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    i_imm = 32'($signed(ins) >>> 20);
    s_imm = {i_imm[31:5], ins[11:7]};
    b_imm = (ins[31] ? 32'hFFFFF000 : 32'h0) + (32'(ins[7]) << 11)
          + (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
    u_imm = ins & 32'hFFFFF000;
    j_imm = (ins[31] ? 32'hFFF00000 : 32'h0) + (32'(ins[19:12]) << 12)
          + (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
    d = '0;
    d.pc = p; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
    bad = 1'b0;
    if (opc == 7'h33) begin
      bad  = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      d.alu = (f7 == 7'h20) ? {3'b001, f3} : {3'b000, f3};
      d.rw = 1'b1;
    end else if (opc == 7'h13) begin
      d.alu  = (f3 == 3'd5 && f7[5]) ? {3'b001, f3} : {3'b000, f3};
      d.imm  = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : i_imm;
      d.bsel = 1'b1; d.rw = 1'b1;
    end else if (opc == 7'h63) begin
      d.alu = {3'b010, f3}; d.br = 1'b1; d.imm = b_imm;
    end else if (opc == 7'h6F || opc == 7'h67) begin
      d.alu = 6'b011000; d.asel = 2'b10; d.j = 1'b1; d.rw = 1'b1;
      d.imm = (opc == 7'h6F) ? j_imm : i_imm;
    end else if (opc == 7'h37) begin
      d.asel = 2'b11; d.bsel = 1'b1; d.rw = 1'b1; d.imm = u_imm;
    end else if (opc == 7'h17) begin
      d.asel = 2'b01; d.bsel = 1'b1; d.rw = 1'b1; d.imm = u_imm;
    end else if (opc == 7'h03) begin
      d.bsel = 1'b1; d.mr = 1'b1; d.rw = 1'b1; d.imm = i_imm;
    end else if (opc == 7'h23) begin
      d.bsel = 1'b1; d.mw = 1'b1; d.imm = s_imm;
    end else begin
      bad = 1'b1;
    end
    if (bad) begin
      d.alu = '0; d.br = 1'b0; d.imm = '0; d.asel = '0; d.bsel = 1'b0;
      d.rw = 1'b0; d.mr = 1'b0; d.mw = 1'b0; d.j = 1'b0; d.ill = 1'b1;
    end
    return d;
  endfunction

  // Drive one cycle's inputs, sample outputs before the edge, advance to the next negedge.
  task automatic tick(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl);
    in_valid = iv; instruction = ins; pc = p; out_ready = ordy; flush = fl;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs = {pc_out, ALU_Control, branch_op, imm, rs1, rs2, rd, op_a_sel, op_b_sel,
           reg_write, mem_read, mem_write, jump, illegal};
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (obs_out_valid !== 1'b0 || obs !== '0) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b fields=%h, want 0 and 0", obs_out_valid, obs);
    end
    reset = 1'b0;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b, want 1 0", obs_in_ready, obs_out_valid);
    end
    // Reset while a word sits in the stage discards it.
    tick(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (obs_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midflight: out_valid=%b, want 0", obs_out_valid);
    end
  endtask

  task automatic test_decode_vectors();
    logic [31:0] ins_t [6] = '{32'h002081B3, 32'h402081B3, 32'h40335293,
                               32'hFE209CE3, 32'h008000EF, 32'h0000007F};
    logic [5:0]  alu_t [6] = '{6'h00, 6'h08, 6'h0D, 6'h11, 6'h18, 6'h00};
    logic [31:0] imm_t [6] = '{32'h0, 32'h0, 32'h3, 32'hFFFFFFF8, 32'h8, 32'h0};
    logic        imm_chk [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // {reg_write, mem_read, mem_write, jump, branch_op, illegal}
    logic [5:0]  ctl_t [6] = '{6'b100000, 6'b100000, 6'b100000,
                               6'b000010, 6'b100100, 6'b000001};
    for (int k = 0; k < 6; k++) begin
      logic [31:0] p;
      dec_t        e;
      p = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      e = ref_decode(ins_t[k], p);
      tick(1'b1, ins_t[k], p, 1'b1, 1'b0);
      vectors++;
      if (obs_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d_idle: out_valid=%b before accept, want 0", k, obs_out_valid);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      vectors++;
      if (obs_out_valid !== 1'b1 || obs !== e) begin
        miscompares++;
        $display("FAIL vec%0d_word: valid=%b got %h want %h", k, obs_out_valid, obs, e);
      end
      vectors++;
      if (obs.alu !== alu_t[k] || {obs.rw, obs.mr, obs.mw, obs.j, obs.br, obs.ill} !== ctl_t[k]) begin
        miscompares++;
        $display("FAIL vec%0d_ctrl: alu=%b ctl=%b want alu=%b ctl=%b", k, obs.alu,
                 {obs.rw, obs.mr, obs.mw, obs.j, obs.br, obs.ill}, alu_t[k], ctl_t[k]);
      end
      if (imm_chk[k]) begin
        vectors++;
        if (obs.imm !== imm_t[k]) begin
          miscompares++;
          $display("FAIL vec%0d_imm: got %h want %h", k, obs.imm, imm_t[k]);
        end
      end
      if (k == 0) begin
        vectors++;
        if (obs.rs1 !== 5'd1 || obs.rs2 !== 5'd2 || obs.rd !== 5'd3 || obs.bsel !== 1'b0) begin
          miscompares++;
          $display("FAIL add_fields: rs1=%0d rs2=%0d rd=%0d bsel=%b want 1 2 3 0",
                   obs.rs1, obs.rs2, obs.rd, obs.bsel);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] list [3] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3};
    logic [31:0] pcs  [3] = '{32'h200, 32'h204, 32'h208};
    int   s = 0;
    int   r = 0;
    dec_t prev = '0;
    logic prev_stall = 1'b0;
    logic ordy;
    for (int cyc = 0; cyc < 20 && r < 3; cyc++) begin
      ordy = (cyc >= 3);
      tick(s < 3, (s < 3) ? list[s] : 32'h0, (s < 3) ? pcs[s] : 32'h0, ordy, 1'b0);
      if (prev_stall) begin
        vectors++;
        if (obs_out_valid !== 1'b1 || obs !== prev) begin
          miscompares++;
          $display("FAIL b2b_hold: valid=%b got %h want %h", obs_out_valid, obs, prev);
        end
      end
      if (cyc == 1) begin
        vectors++;
        if (obs_in_ready !== (DEPTH == 2)) begin
          miscompares++;
          $display("FAIL b2b_ready1: in_ready=%b want %b", obs_in_ready, DEPTH == 2);
        end
      end
      if (cyc == 2) begin
        vectors++;
        if (obs_in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready2: in_ready=%b want 0", obs_in_ready);
        end
      end
      if (obs_out_valid && ordy) begin
        vectors++;
        if (obs !== ref_decode(list[r], pcs[r])) begin
          miscompares++;
          $display("FAIL b2b_order%0d: got %h want %h", r, obs, ref_decode(list[r], pcs[r]));
        end
        r++;
      end
      if (s < 3 && obs_in_ready) s++;
      prev       = obs;
      prev_stall = obs_out_valid && !ordy;
    end
    vectors++;
    if (r != 3) begin
      miscompares++;
      $display("FAIL b2b_drain: drained %0d words, want 3", r);
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    tick(1'b1, 32'h00A00093, 32'h300, 1'b0, 1'b0);
    tick(1'b1, 32'h00B00113, 32'h304, 1'b0, 1'b0);
    tick(1'b1, 32'h00C00193, 32'h308, 1'b0, 1'b1);
    vectors++;
    if (obs_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre: out_valid=%b want 1", obs_out_valid);
    end
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_post: out_valid=%b in_ready=%b want 0 1", obs_out_valid, obs_in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (obs_out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_quiet: flushed word reappeared=%b want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    dec_t        q [$];
    logic [31:0] ins, p;
    logic        iv, ordy, fl, exp_ov, exp_ir;
    int          sel;
    for (int cyc = 0; cyc < 460; cyc++) begin
      ins = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 9) ins[6:0] = ops[sel];
      if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
        ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if (ins[6:0] == 7'h13 && $urandom_range(0, 1) != 0)
        ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      p    = $urandom;
      // The last cycles only drain.
      iv   = (cyc < 400) && ($urandom_range(0, 3) != 0);
      fl   = (cyc < 400) && ($urandom_range(0, 15) == 0);
      ordy = !fl && ((cyc >= 400) || ($urandom_range(0, 2) != 0));
      exp_ov = (q.size() > 0);
      exp_ir = (q.size() < DEPTH) || (DEPTH == 1 && ordy);
      tick(iv, ins, p, ordy, fl);
      vectors++;
      if (obs_out_valid !== exp_ov || obs_in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL rnd_hs cyc%0d: valid=%b ready=%b want %b %b",
                 cyc, obs_out_valid, obs_in_ready, exp_ov, exp_ir);
      end
      if (obs_out_valid && ordy) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_extra cyc%0d: got %h, want no word", cyc, obs);
        end else begin
          if (obs !== q[0]) begin
            miscompares++;
            $display("FAIL rnd_word cyc%0d: got %h want %h", cyc, obs, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (fl) q.delete();
      else if (iv && obs_in_ready) q.push_back(ref_decode(ins, p));
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain: %0d words never delivered, want 0", q.size());
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 32'h0; pc = 32'h0;
    @(negedge clock);
    test_reset();
    test_decode_vectors();
    test_back_to_back();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
